rssi_cca_detect: RTL

Energy-detect clear-channel-assessment stage that consumes the calibrated `rssi_half_db` / `rssi_half_db_valid` stream from the xpu RSSI stage. It compares each sample against a programmable threshold with hysteresis and per-direction debounce. It produces a registered channel busy/idle flag for the CSMA/backoff logic, one-cycle edge strobes, and a saturating busy-time statistic for software channel-occupancy reporting.

---
 rtl/rssi_cca_detect.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rssi_cca_detect.sv
// Energy-detect clear-channel assessment: RSSI threshold with hysteresis and
// per-direction debounce, busy/idle edge strobes and a saturating busy-time counter.
module rssi_cca_detect #(
    parameter int unsigned RSSI_HALF_DB_WIDTH = 11,
    parameter int unsigned DEBOUNCE_WIDTH     = 4,
    parameter int unsigned STAT_WIDTH         = 32
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
    input  logic                                 rssi_half_db_valid,
    input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_th,
    input  logic        [RSSI_HALF_DB_WIDTH-2:0] rssi_hyst,
    input  logic        [DEBOUNCE_WIDTH-1:0]     busy_confirm,
    input  logic        [DEBOUNCE_WIDTH-1:0]     idle_confirm,
    input  logic                                 force_busy,
    input  logic                                 stat_clear,
    output logic                                 ch_busy,
    output logic                                 busy_rise,
    output logic                                 busy_fall,
    output logic        [STAT_WIDTH-1:0]         busy_sample_count,
    output logic        [1:0]                    fsm_state
);

    localparam int unsigned EW = RSSI_HALF_DB_WIDTH + 1;
    localparam int unsigned CW = DEBOUNCE_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PEND_BUSY = 2'd1,
        ST_BUSY      = 2'd2,
        ST_PEND_IDLE = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      ch_busy_q, ch_busy_d;
    logic                      busy_prev_q;
    logic                      busy_rise_q, busy_rise_d;
    logic                      busy_fall_q, busy_fall_d;
    logic [STAT_WIDTH-1:0]     stat_q, stat_d;

    // One extra bit keeps th_low = th - hyst free of wrap-around.
    logic signed [EW-1:0]      rssi_ext, th_ext, hyst_ext, th_low;
    logic                      hi, lo;
    logic [DEBOUNCE_WIDTH-1:0] n_busy, n_idle;
    logic [CW-1:0]             cnt_inc;
    logic                      busy_done, idle_done;

    assign rssi_ext = EW'(rssi_half_db);
    assign th_ext   = EW'(rssi_th);
    assign hyst_ext = EW'(rssi_hyst);
    assign th_low   = th_ext - hyst_ext;
    assign hi       = (rssi_ext >= th_ext);
    assign lo       = (rssi_ext < th_low);

    assign n_busy    = (busy_confirm == '0) ? DEBOUNCE_WIDTH'(1) : busy_confirm;
    assign n_idle    = (idle_confirm == '0) ? DEBOUNCE_WIDTH'(1) : idle_confirm;
    assign cnt_inc   = CW'(cnt_q) + CW'(1);
    // >= so a run already past a freshly lowered confirm count still completes.
    assign busy_done = (cnt_inc >= CW'(n_busy));
    assign idle_done = (cnt_inc >= CW'(n_idle));

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and debounce counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_busy) begin
            state_d = ST_BUSY;
            cnt_d   = '0;
        end else if (rssi_half_db_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hi) begin
                        if (n_busy == DEBOUNCE_WIDTH'(1)) begin
                            state_d = ST_BUSY;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_PEND_BUSY;
                            cnt_d   = DEBOUNCE_WIDTH'(1);
                        end
                    end
                end
                ST_PEND_BUSY: begin
                    if (!hi) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (busy_done) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[DEBOUNCE_WIDTH-1:0];
                    end
                end
                ST_BUSY: begin
                    if (lo) begin
                        if (n_idle == DEBOUNCE_WIDTH'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_PEND_IDLE;
                            cnt_d   = DEBOUNCE_WIDTH'(1);
                        end
                    end
                end
                ST_PEND_IDLE: begin
                    if (!lo) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                    end else if (idle_done) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[DEBOUNCE_WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output next values: busy flag, edge strobes, occupancy statistic
    always_comb begin
        ch_busy_d   = (state_d == ST_BUSY) || (state_d == ST_PEND_IDLE);
        busy_rise_d = ch_busy_q & ~busy_prev_q;
        busy_fall_d = ~ch_busy_q & busy_prev_q;
        stat_d      = stat_q;
        if (stat_clear) begin
            stat_d = '0;
        end else if (rssi_half_db_valid && ch_busy_q && (stat_q != '1)) begin
            stat_d = stat_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_busy_q   <= 1'b0;
            busy_prev_q <= 1'b0;
            busy_rise_q <= 1'b0;
            busy_fall_q <= 1'b0;
            stat_q      <= '0;
        end else begin
            ch_busy_q   <= ch_busy_d;
            busy_prev_q <= ch_busy_q;
            busy_rise_q <= busy_rise_d;
            busy_fall_q <= busy_fall_d;
            stat_q      <= stat_d;
        end
    end

    assign ch_busy           = ch_busy_q;
    assign busy_rise         = busy_rise_q;
    assign busy_fall         = busy_fall_q;
    assign busy_sample_count = stat_q;
    assign fsm_state         = state_q;

endmodule
